// File: rtl/uart_arb_pkg.sv
// Shared constants and helpers for the two-port UART transmit arbiter.
// Holds the byte width, port count, FSM state encodings and the
// round-robin selection rule used by the arbiter.
package uart_arb_pkg;

  localparam int BYTE_W    = 8;
  localparam int NUM_PORTS = 2;

  // FSM state encodings, kept as plain 3-bit constants so the
  // encoding stays fixed in waveforms and downstream tooling.
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE        = 3'd0;
  localparam state_t ST_LOAD        = 3'd1;
  localparam state_t ST_WAIT_ACTIVE = 3'd2;
  localparam state_t ST_WAIT_DONE   = 3'd3;
  localparam state_t ST_GAP         = 3'd4;

  // Round-robin pick between the two ports.
  // When both have data, the port that did not win last time goes next;
  // otherwise the only non-empty port wins. Only meaningful when at
  // least one bit of nonempty is set.
  function automatic logic pick_port(input logic [NUM_PORTS-1:0] nonempty,
                                     input logic                 last_grant);
    logic sel;
    if (&nonempty) begin
      sel = ~last_grant;
    end else if (nonempty[0]) begin
      sel = 1'b0;
    end else begin
      sel = 1'b1;
    end
    return sel;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous byte FIFO with first-word-fall-through read.
// rd_data always shows the oldest stored byte; rd_en consumes it.
// Occupancy is tracked with one extra bit so full and empty are
// distinguishable while the pointers wrap modulo the depth.
module byte_fifo
  import uart_arb_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [BYTE_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [BYTE_W-1:0]     r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;

  logic w_push;
  logic w_pop;

  // Status flags come straight from the registered occupancy.
  assign full    = (r_count == FULL_COUNT);
  assign empty   = (r_count == '0);
  assign w_push  = wr_en && !full;
  assign w_pop   = rd_en && !empty;
  assign rd_data = r_mem[r_rd_ptr];

  // Storage array write.
  // NOTE: the data array is deliberately left out of reset: it is only
  // read behind a non-empty count, and a reset here would turn the RAM
  // into a large bank of flops. Sequential state always uses <= so every
  // register samples the pre-edge values of its inputs.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; the pointers wrap naturally at their width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serialiser between two byte producers.
// Port 0 is the CPU debug stream, port 1 the RX echo/monitor stream.
// Each port has its own FIFO; a round-robin FSM drains them one byte at
// a time, waits for the serialiser to finish, then enforces an idle gap
// before the next byte is loaded.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2,
  parameter int GAP_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] req0_data,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [BYTE_W-1:0] req1_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  output logic              tx_dv,
  output logic [BYTE_W-1:0] tx_byte,
  input  logic              tx_active,
  input  logic              tx_done,
  output logic [1:0]        ovf,
  output logic              busy
);

  // Gap counter reload: the GAP state lasts exactly GAP_CYCLES cycles.
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  state_t            r_state;
  logic              r_last_grant;
  logic [7:0]        r_gap;
  logic [BYTE_W-1:0] r_tx_byte;
  logic              r_tx_dv;
  logic [1:0]        r_ovf;
  logic              r_live;

  logic [1:0]        w_full;
  logic [1:0]        w_empty;
  logic [1:0]        w_ready;
  logic [1:0]        w_wr_en;
  logic [1:0]        w_pop;
  logic [BYTE_W-1:0] w_rd_data0;
  logic [BYTE_W-1:0] w_rd_data1;
  logic              w_start;
  logic              w_sel;

  // Producer handshake. Ready is low during reset and for the first
  // cycle after it, then follows the registered FIFO occupancy, so a pop
  // from a full FIFO cannot reopen ready in the same cycle.
  assign w_ready    = ~w_full & {2{r_live}};
  assign w_wr_en[0] = req0_valid && w_ready[0];
  assign w_wr_en[1] = req1_valid && w_ready[1];
  assign req0_ready = w_ready[0];
  assign req1_ready = w_ready[1];

  // Launch a byte only from IDLE, only when the serialiser is quiet
  // (it has no reset and may still be mid-frame after ours), and only
  // when some FIFO has data.
  assign w_start  = (r_state == ST_IDLE) && !tx_active && (w_empty != 2'b11);
  assign w_sel    = pick_port(~w_empty, r_last_grant);
  assign w_pop[0] = w_start && !w_sel;
  assign w_pop[1] = w_start &&  w_sel;

  assign tx_dv   = r_tx_dv;
  assign tx_byte = r_tx_byte;
  assign ovf     = r_ovf;
  assign busy    = (r_state != ST_IDLE);

  byte_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo0 (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (w_wr_en[0]),
    .wr_data (req0_data),
    .rd_en   (w_pop[0]),
    .rd_data (w_rd_data0),
    .full    (w_full[0]),
    .empty   (w_empty[0])
  );

  byte_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo1 (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (w_wr_en[1]),
    .wr_data (req1_data),
    .rd_en   (w_pop[1]),
    .rd_data (w_rd_data1),
    .full    (w_full[1]),
    .empty   (w_empty[1])
  );

  // Hold ready low for one cycle after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
    end
  end

  // Sticky per-port overflow: a byte offered while the port is not ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 2'b00;
    end else begin
      r_ovf <= r_ovf | {req1_valid & ~w_ready[1], req0_valid & ~w_ready[0]};
    end
  end

  // Arbitration FSM: pick and pop in IDLE, pulse tx_dv in LOAD, follow
  // the serialiser through its frame, then sit out the idle gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_gap        <= 8'd0;
      r_tx_byte    <= '0;
      r_tx_dv      <= 1'b0;
    end else begin
      r_tx_dv <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_tx_byte    <= w_sel ? w_rd_data1 : w_rd_data0;
            r_last_grant <= w_sel;
            r_tx_dv      <= 1'b1;
            r_state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_state <= ST_WAIT_ACTIVE;
        end
        ST_WAIT_ACTIVE: begin
          // A done pulse here means the frame collapsed before active
          // was ever seen; it wins over active so it is never missed.
          if (tx_done) begin
            r_gap   <= GAP_LOAD;
            r_state <= ST_GAP;
          end else if (tx_active) begin
            r_state <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          // No timeout: a lost done pulse parks here until reset.
          if (tx_done) begin
            r_gap   <= GAP_LOAD;
            r_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (r_gap == 8'd0) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap <= r_gap - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter.
// A negedge process models uart_tx (active for a fixed frame length,
// then a done pulse) and keeps a queue-based reference of both FIFOs
// with the round-robin rule, checking every byte the DUT launches.
// Directed steps in the main initial block cover the specific scenarios;
// a final randomized phase exercises both ports together.
module tb_uart_tx_arbiter;

  localparam int DEPTH_LOG2      = 2;
  localparam int GAP_CYCLES      = 16;
  localparam int FRAME_CYCLES    = 10;
  localparam int COLLAPSE_CYCLES = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req0_data;
  logic       req0_valid;
  logic       req0_ready;
  logic [7:0] req1_data;
  logic       req1_valid;
  logic       req1_ready;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_active = 1'b0;
  logic       tx_done   = 1'b0;
  logic [1:0] ovf;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model and uart_tx model state.
  logic [7:0] m_q0[$];
  logic [7:0] m_q1[$];
  logic [7:0] sent_q[$];
  logic       m_last        = 1'b1;
  logic [1:0] exp_ovf       = 2'b00;
  logic       pend0         = 1'b0;
  logic       pend1         = 1'b0;
  logic [7:0] pd0           = 8'h00;
  logic [7:0] pd1           = 8'h00;
  logic       prev_dv       = 1'b0;
  logic       new_dv        = 1'b0;
  logic       sel           = 1'b0;
  logic [7:0] exp_b         = 8'h00;
  logic [7:0] hold_byte     = 8'h00;
  logic       m_active      = 1'b0;
  int         m_cnt         = 0;
  int         ncyc          = 0;
  int         done_n        = 0;
  int         done_cnt      = 0;
  int         dv_cnt        = 0;
  int         dv_gap        = 0;
  int         acc_cnt       = 0;
  logic       force_active  = 1'b0;
  logic       collapse_mode = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .GAP_CYCLES (GAP_CYCLES)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .req0_data  (req0_data),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req1_data  (req1_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .tx_dv      (tx_dv),
    .tx_byte    (tx_byte),
    .tx_active  (tx_active),
    .tx_done    (tx_done),
    .ovf        (ovf),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_tests++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!(req0_ready && req1_ready) && k < 10) begin
      tick();
      k++;
    end
    check("ready_after_reset", {30'd0, req0_ready, req1_ready}, 32'd3);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    wait_ready();
  endtask

  task automatic wait_done(input int prev);
    int k = 0;
    while (done_cnt == prev && k < 300) begin
      tick();
      k++;
    end
    check("done_seen", {31'd0, done_cnt != prev}, 32'd1);
  endtask

  task automatic wait_drain();
    int k = 0;
    int stable = 0;
    while (stable < 3 && k < 3000) begin
      tick();
      k++;
      if (!busy && !tx_active && m_cnt == 0 && m_q0.size() == 0 && m_q1.size() == 0)
        stable++;
      else
        stable = 0;
    end
    check("drain", stable, 3);
  endtask

  task automatic push0(input logic [7:0] b);
    req0_data  = b;
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
  endtask

  // Monitor, reference model and uart_tx model, all mid-cycle.
  always @(negedge clk) begin
    ncyc++;
    new_dv = 1'b0;
    if (reset) begin
      m_q0.delete();
      m_q1.delete();
      m_last    = 1'b1;
      exp_ovf   = 2'b00;
      pend0     = 1'b0;
      pend1     = 1'b0;
      hold_byte = 8'h00;
      prev_dv   = 1'b0;
    end else begin
      if (tx_dv) begin
        check("dv_single_cycle", {31'd0, prev_dv}, 32'd0);
        if (!prev_dv) begin
          new_dv = 1'b1;
          check("dv_while_active", {31'd0, tx_active}, 32'd0);
          check("dv_source", {31'd0, (m_q0.size() + m_q1.size()) != 0}, 32'd1);
          if (m_q0.size() != 0 && m_q1.size() != 0) sel = ~m_last;
          else sel = (m_q0.size() == 0);
          if (m_q0.size() + m_q1.size() != 0) begin
            exp_b = sel ? m_q1.pop_front() : m_q0.pop_front();
            check("tx_byte", {24'd0, tx_byte}, {24'd0, exp_b});
            m_last = sel;
          end
          hold_byte = tx_byte;
          sent_q.push_back(tx_byte);
          dv_cnt++;
          dv_gap = ncyc - done_n;
        end
      end else begin
        check("tx_byte_hold", {24'd0, tx_byte}, {24'd0, hold_byte});
      end
      // Pushes accepted at the edge just passed land behind any pop there.
      if (pend0) begin m_q0.push_back(pd0); acc_cnt++; end
      if (pend1) begin m_q1.push_back(pd1); acc_cnt++; end
      if (req0_valid && !req0_ready) exp_ovf[0] = 1'b1;
      if (req1_valid && !req1_ready) exp_ovf[1] = 1'b1;
      pend0   = req0_valid && req0_ready;
      pend1   = req1_valid && req1_ready;
      pd0     = req0_data;
      pd1     = req1_data;
      prev_dv = tx_dv;
    end
    // uart_tx model: it has no reset, so a frame survives ours.
    if (tx_done) tx_done = 1'b0;
    if (new_dv) begin
      if (collapse_mode) begin
        m_cnt = COLLAPSE_CYCLES;
      end else begin
        m_active = 1'b1;
        m_cnt    = FRAME_CYCLES;
      end
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_active = 1'b0;
        tx_done  = 1'b1;
        done_cnt++;
        done_n   = ncyc;
      end
    end
    tx_active = m_active | force_active;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    n_fail++;
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp2[8];
    int         d;
    logic       dv_seen;

    reset      = 1'b1;
    req0_data  = 8'h00;
    req0_valid = 1'b0;
    req1_data  = 8'h00;
    req1_valid = 1'b0;
    tick();
    tick();

    // Reset values.
    check("rst_ready0", {31'd0, req0_ready}, 32'd0);
    check("rst_ready1", {31'd0, req1_ready}, 32'd0);
    check("rst_tx_dv",  {31'd0, tx_dv}, 32'd0);
    check("rst_tx_byte", {24'd0, tx_byte}, 32'h00);
    check("rst_ovf",    {30'd0, ovf}, 32'd0);
    check("rst_busy",   {31'd0, busy}, 32'd0);
    reset = 1'b0;
    wait_ready();

    // 1) Single byte: uart_tx captures tx_dv on the second edge after the push.
    sent_q.delete();
    d = done_cnt;
    push0(8'h41);
    check("t1_dv_not_yet", {31'd0, tx_dv}, 32'd0);
    tick();
    check("t1_dv", {31'd0, tx_dv}, 32'd1);
    check("t1_byte", {24'd0, tx_byte}, 32'h41);
    tick();
    check("t1_dv_pulse", {31'd0, tx_dv}, 32'd0);
    wait_done(d);
    repeat (GAP_CYCLES - 1) tick();
    check("t1_busy_in_gap", {31'd0, busy}, 32'd1);
    tick();
    check("t1_busy_after_gap", {31'd0, busy}, 32'd0);
    wait_drain();

    // 2) Both ports preloaded: strict alternation starting with port 0.
    apply_reset();
    sent_q.delete();
    d = dv_cnt;
    force_active = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req0_data  = 8'hA0 + 8'(i);
      req1_data  = 8'hB0 + 8'(i);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      tick();
    end
    req0_valid   = 1'b0;
    req1_valid   = 1'b0;
    force_active = 1'b0;
    wait_drain();
    exp2 = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2, 8'hA3, 8'hB3};
    check("t2_dv_count", dv_cnt - d, 8);
    check("t2_sent_count", sent_q.size(), 8);
    for (int i = 0; i < 8 && i < sent_q.size(); i++)
      check("t2_order", {24'd0, sent_q[i]}, {24'd0, exp2[i]});

    // 3) Port 1 overfilled while the serialiser is held busy.
    apply_reset();
    sent_q.delete();
    force_active = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req1_data  = 8'hC0 + 8'(i);
      req1_valid = 1'b1;
      tick();
      if (i == 2) check("t3_ready_before_full", {31'd0, req1_ready}, 32'd1);
      if (i == 3) check("t3_ready_full", {31'd0, req1_ready}, 32'd0);
    end
    req1_valid = 1'b0;
    check("t3_ovf", {30'd0, ovf}, 32'd2);
    force_active = 1'b0;
    wait_drain();
    check("t3_sent_count", sent_q.size(), 4);
    if (sent_q.size() == 4) check("t3_last_byte", {24'd0, sent_q[3]}, 32'hC3);
    check("t3_ovf_sticky", {30'd0, ovf}, 32'd2);
    check("t3_ready_again", {31'd0, req1_ready}, 32'd1);

    // 4) Push and pop on the same edge with two entries queued, through wrap.
    apply_reset();
    sent_q.delete();
    force_active = 1'b1;
    for (int i = 0; i < 3; i++) push0(8'(i));
    d = done_cnt;
    force_active = 1'b0;
    for (int i = 0; i < 12; i++) begin
      wait_done(d);
      d = done_cnt;
      repeat (GAP_CYCLES) tick();
      check("t4_count_before", {29'd0, u_dut.u_fifo0.r_count}, 32'd2);
      check("t4_ready_before", {31'd0, req0_ready}, 32'd1);
      push0(8'(3 + i));
      check("t4_ready_after", {31'd0, req0_ready}, 32'd1);
      check("t4_count_after", {29'd0, u_dut.u_fifo0.r_count}, 32'd2);
    end
    wait_drain();
    check("t4_sent_count", sent_q.size(), 15);
    for (int i = 0; i < 15 && i < sent_q.size(); i++)
      check("t4_order", {24'd0, sent_q[i]}, i);

    // 5) Reset while the frame is in flight; no launch until active falls.
    apply_reset();
    sent_q.delete();
    push0(8'h55);
    repeat (4) tick();
    check("t5_busy_in_frame", {31'd0, busy}, 32'd1);
    check("t5_active_in_frame", {31'd0, tx_active}, 32'd1);
    force_active = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    check("t5_busy_in_reset", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    wait_ready();
    push0(8'h66);
    dv_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (tx_dv) dv_seen = 1'b1;
    end
    check("t5_dv_blocked", {31'd0, dv_seen}, 32'd0);
    force_active = 1'b0;
    wait_drain();
    check("t5_sent_count", sent_q.size(), 2);
    if (sent_q.size() == 2) check("t5_new_byte", {24'd0, sent_q[1]}, 32'h66);

    // 6) Collapsed frame: done without active, then the full gap.
    apply_reset();
    sent_q.delete();
    collapse_mode = 1'b1;
    push0(8'h10);
    push0(8'h11);
    wait_drain();
    collapse_mode = 1'b0;
    check("t6_sent_count", sent_q.size(), 2);
    check("t6_gap", dv_gap, GAP_CYCLES + 2);

    // 7) Random traffic on both ports, including offers while not ready.
    apply_reset();
    sent_q.delete();
    acc_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      req0_valid = ($urandom_range(3, 0) == 0);
      req1_valid = ($urandom_range(3, 0) == 0);
      req0_data  = 8'($urandom);
      req1_data  = 8'($urandom);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_drain();
    check("t7_ovf", {30'd0, ovf}, {30'd0, exp_ovf});
    check("t7_sent_vs_accepted", sent_q.size(), acc_cnt);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
